// File: rtl/prog_pulse_generator.sv
// Programmable pulse-burst generator: a synchronized rising edge on start emits
// pulse_num pulses of pulse_width cycles separated by gap_width low cycles.
module prog_pulse_generator #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 4
) (
    input  logic             clk_8M,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap_width,
    input  logic [NUM_W-1:0] pulse_num,
    output logic             start_pulse,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             start_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] width_lat;
    logic [CNT_W-1:0] gap_lat;
    logic [NUM_W-1:0] num_lat;

    // Synchronizer resets high so a start already held high at reset release is not an edge.
    always_ff @(posedge clk_8M or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_edge = sync2 & ~sync3;

    always_ff @(posedge clk_8M or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            start_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_idx   <= '0;
            cnt         <= '0;
            width_lat   <= '0;
            gap_lat     <= '0;
            num_lat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    start_pulse <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    pulse_idx   <= '0;
                    if (start_edge && !abort) begin
                        state       <= HIGH;
                        start_pulse <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= CNT_W'(1);
                        width_lat   <= (pulse_width == '0) ? CNT_W'(1) : pulse_width;
                        gap_lat     <= (gap_width == '0) ? CNT_W'(1) : gap_width;
                        num_lat     <= (pulse_num == '0) ? NUM_W'(1) : pulse_num;
                    end
                end

                // cnt counts the cycles already spent in the phase, starting at 1.
                HIGH: begin
                    if (abort) begin
                        state       <= IDLE;
                        start_pulse <= 1'b0;
                        busy        <= 1'b0;
                        pulse_idx   <= '0;
                        cnt         <= '0;
                    end else if (cnt == width_lat) begin
                        start_pulse <= 1'b0;
                        cnt         <= CNT_W'(1);
                        if (pulse_idx < (num_lat - NUM_W'(1))) begin
                            state <= GAP;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (abort) begin
                        state       <= IDLE;
                        start_pulse <= 1'b0;
                        busy        <= 1'b0;
                        pulse_idx   <= '0;
                        cnt         <= '0;
                    end else if (cnt == gap_lat) begin
                        state       <= HIGH;
                        start_pulse <= 1'b1;
                        cnt         <= CNT_W'(1);
                        pulse_idx   <= pulse_idx + NUM_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state       <= IDLE;
                    start_pulse <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    pulse_idx   <= '0;
                    cnt         <= '0;
                end

                default: begin
                    state       <= IDLE;
                    start_pulse <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    pulse_idx   <= '0;
                    cnt         <= '0;
                end
            endcase
        end
    end

endmodule
